wb_dma_copy: RTL and testbench

Wishbone pipelined bus master (initiator) that copies a block of 32-bit words from a source to a destination byte address.
- Reads up to BURST words into a local buffer, then writes them out; repeats until the requested length is moved.
- Drives the slave-side RAM and peripheral ports on the shared if_wb fabric.
- Started by a simple start/busy/done command handshake from the CPU or control logic.

---
 rtl/wb_dma_pkg.sv | 25 ++
 rtl/wb_dma_copy_if.sv | 23 ++
 rtl/wb_dma_buf.sv | 24 ++
 rtl/wb_dma_copy.sv | 245 ++++++++++++++++++++++++
 tb/tb_wb_dma_copy.sv | 348 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/wb_dma_pkg.sv
// Shared types and constants for the Wishbone block-copy DMA.
// Optional feature macro: WB_DMA_TIMEOUT_EN (ack timeout abort).
package wb_dma_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_GAP,
        S_WR,
        S_DONE
    } state_e;

    typedef enum logic {
        PH_READ,
        PH_WRITE
    } phase_e;

    localparam logic [3:0]  SEL_ALL    = 4'hF;
    localparam logic [31:0] WORD_BYTES = 32'd4;

    function automatic logic [31:0] word_align(input logic [31:0] a);
        return {a[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/wb_dma_copy_if.sv
// Wishbone B4 pipelined bus bundle shared by the DMA master
// and the RAM/peripheral slaves on the fabric.
interface if_wb;
    logic        cyc;
    logic        stb;
    logic        we;
    logic [31:0] adr;
    logic [3:0]  sel;
    logic [31:0] dat_m;
    logic [31:0] dat_s;
    logic        ack;
    logic        stall;

    modport master (
        output cyc, stb, we, adr, sel, dat_m,
        input  dat_s, ack, stall
    );

    modport slave (
        input  cyc, stb, we, adr, sel, dat_m,
        output dat_s, ack, stall
    );
endinterface

// File: rtl/wb_dma_buf.sv
// Burst staging buffer: written by read acks, read
// combinationally by the write-phase request index.
module wb_dma_buf #(
    parameter int BURST = 4,
    parameter int AW    = 2
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [31:0]   wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [31:0]   rdata_o
);

    logic [31:0] mem_q [2**AW];

    // Capture read data; payload needs no reset.
    always_ff @(posedge clk_i) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/wb_dma_copy.sv
// Wishbone pipelined block-copy master: read burst, gap, write burst.
// Optional feature macro: WB_DMA_TIMEOUT_EN (abort after TIMEOUT idle cycles).
module wb_dma_copy
    import wb_dma_pkg::*;
#(
    parameter int LWIDTH  = 16,
    parameter int BURST   = 4,
    parameter int TIMEOUT = 64
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              start_i,
    input  logic [31:0]       src_i,
    input  logic [31:0]       dst_i,
    input  logic [LWIDTH-1:0] len_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o,
    if_wb.master              bus
);

    localparam int AW = (BURST > 1) ? $clog2(BURST) : 1;
    localparam int NW = $clog2(BURST) + 1;
    localparam logic [NW-1:0]     BURST_N = NW'(BURST);
    localparam logic [LWIDTH-1:0] BURST_L = LWIDTH'(BURST);

    function automatic logic [NW-1:0] burst_len(input logic [LWIDTH-1:0] r);
        if (r >= BURST_L) return BURST_N;
        return r[NW-1:0];
    endfunction

    state_e            state_q, state_d;
    phase_e            phase_q, phase_d;
    logic [31:0]       src_q, src_d;
    logic [31:0]       dst_q, dst_d;
    logic [LWIDTH-1:0] rem_q, rem_d;
    logic [NW-1:0]     n_q, n_d;
    logic [NW-1:0]     req_q, req_d;
    logic [NW-1:0]     ack_q, ack_d;
    logic              cyc_q, cyc_d;
    logic              stb_q, stb_d;
    logic              we_q, we_d;
    logic [31:0]       adr_q, adr_d;
    logic [3:0]        sel_q, sel_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              acc;
    logic              ack;
    logic [31:0]       buf_rdata;

`ifdef WB_DMA_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] wait_q, wait_d;
`endif

    wb_dma_buf #(.BURST(BURST), .AW(AW)) u_buf (
        .clk_i   (clk_i),
        .we_i    (state_q == S_RD && ack),
        .waddr_i (ack_q[AW-1:0]),
        .wdata_i (bus.dat_s),
        .raddr_i (req_q[AW-1:0]),
        .rdata_o (buf_rdata)
    );

    // Next-state and next-output logic for the copy sequencer.
    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        src_d   = src_q;
        dst_d   = dst_q;
        rem_d   = rem_q;
        n_d     = n_q;
        req_d   = req_q;
        ack_d   = ack_q;
        cyc_d   = cyc_q;
        stb_d   = stb_q;
        we_d    = we_q;
        adr_d   = adr_q;
        sel_d   = sel_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        acc     = stb_q & ~bus.stall;
        ack     = cyc_q & bus.ack;
`ifdef WB_DMA_TIMEOUT_EN
        wait_d  = wait_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    src_d  = word_align(src_i);
                    dst_d  = word_align(dst_i);
                    rem_d  = len_i;
                    busy_d = 1'b1;
                    req_d  = '0;
                    ack_d  = '0;
                    if (len_i == '0) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_RD;
                        phase_d = PH_READ;
                        n_d     = burst_len(len_i);
                        cyc_d   = 1'b1;
                        stb_d   = 1'b1;
                        we_d    = 1'b0;
                        sel_d   = SEL_ALL;
                        adr_d   = word_align(src_i);
                    end
                end
            end
            S_RD, S_WR: begin
                if (acc) begin
                    adr_d = adr_q + WORD_BYTES;
                    req_d = req_q + NW'(1);
                    if (req_q + NW'(1) == n_q) stb_d = 1'b0;
                end
                if (ack) begin
                    ack_d = ack_q + NW'(1);
                    if (ack_q + NW'(1) == n_q) begin
                        state_d = S_GAP;
                        cyc_d   = 1'b0;
                        stb_d   = 1'b0;
                        we_d    = 1'b0;
                        sel_d   = '0;
                        if (state_q == S_RD) begin
                            src_d = adr_q;
                        end else begin
                            dst_d = adr_q;
                            rem_d = rem_q - LWIDTH'(n_q);
                        end
                    end
                end
`ifdef WB_DMA_TIMEOUT_EN
                if (ack) begin
                    wait_d = '0;
                end else if (req_q != ack_q) begin
                    if (wait_q == TW'(TIMEOUT - 1)) begin
                        state_d = S_IDLE;
                        cyc_d   = 1'b0;
                        stb_d   = 1'b0;
                        we_d    = 1'b0;
                        sel_d   = '0;
                        busy_d  = 1'b0;
                        err_d   = 1'b1;
                        wait_d  = '0;
                    end else begin
                        wait_d = wait_q + TW'(1);
                    end
                end
`endif
            end
            S_GAP: begin
                req_d = '0;
                ack_d = '0;
                if (phase_q == PH_READ) begin
                    state_d = S_WR;
                    phase_d = PH_WRITE;
                    cyc_d   = 1'b1;
                    stb_d   = 1'b1;
                    we_d    = 1'b1;
                    sel_d   = SEL_ALL;
                    adr_d   = dst_q;
                end else if (rem_q != '0) begin
                    state_d = S_RD;
                    phase_d = PH_READ;
                    n_d     = burst_len(rem_q);
                    cyc_d   = 1'b1;
                    stb_d   = 1'b1;
                    we_d    = 1'b0;
                    sel_d   = SEL_ALL;
                    adr_d   = src_q;
                end else begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Register sequencer state and all bus/status outputs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            phase_q <= PH_READ;
            src_q   <= '0;
            dst_q   <= '0;
            rem_q   <= '0;
            n_q     <= '0;
            req_q   <= '0;
            ack_q   <= '0;
            cyc_q   <= 1'b0;
            stb_q   <= 1'b0;
            we_q    <= 1'b0;
            adr_q   <= '0;
            sel_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
`ifdef WB_DMA_TIMEOUT_EN
            wait_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            rem_q   <= rem_d;
            n_q     <= n_d;
            req_q   <= req_d;
            ack_q   <= ack_d;
            cyc_q   <= cyc_d;
            stb_q   <= stb_d;
            we_q    <= we_d;
            adr_q   <= adr_d;
            sel_q   <= sel_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
`ifdef WB_DMA_TIMEOUT_EN
            wait_q  <= wait_d;
`endif
        end
    end

    assign bus.cyc   = cyc_q;
    assign bus.stb   = stb_q;
    assign bus.we    = we_q;
    assign bus.adr   = adr_q;
    assign bus.sel   = sel_q;
    assign bus.dat_m = we_q ? buf_rdata : 32'h0;
    assign busy_o    = busy_q;
    assign done_o    = done_q;
`ifdef WB_DMA_TIMEOUT_EN
    assign err_o     = err_q;
`else
    assign err_o     = 1'b0;
`endif

endmodule

// File: tb/tb_wb_dma_copy.sv
// Scoreboard bench for wb_dma_copy with a pipelined RAM slave model.
// Optional feature macro: WB_DMA_TIMEOUT_EN (adds the no-ack abort case).
module tb_wb_dma_copy;

    typedef struct {
        logic        we;
        logic [31:0] adr;
        logic [31:0] dat;
    } req_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] src = '0;
    logic [31:0] dst = '0;
    logic [15:0] len = '0;
    logic        busy, done, err;

    if_wb bus();

    wb_dma_copy #(.LWIDTH(16), .BURST(4), .TIMEOUT(16)) dut (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .start_i (start),
        .src_i   (src),
        .dst_i   (dst),
        .len_i   (len),
        .busy_o  (busy),
        .done_o  (done),
        .err_o   (err),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int done_cnt = 0;
    int err_cnt = 0;
    int cur_test = 0;
    bit err_allowed = 0;

    req_t exp_q[$];
    int   done_q[$];

    logic [31:0] mem  [bit [31:0]];
    logic [31:0] gold [bit [31:0]];

    bit stall_mode = 0;
    bit noack = 0;
    int acc_n = 0;
    int stall_left = 0;

    initial begin
        bus.ack   = 1'b0;
        bus.stall = 1'b0;
        bus.dat_s = '0;
    end

    function automatic logic [31:0] rd(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return 32'h0;
    endfunction

    // Pipelined slave: ack one cycle after accept, optional stalls.
    always @(posedge clk) begin
        if (bus.cyc && bus.stb && !bus.stall) begin
            acc_n++;
            if (bus.we) mem[bus.adr] = bus.dat_m;
            bus.dat_s <= bus.we ? 32'h0 : rd(bus.adr);
            bus.ack   <= !noack;
            if (stall_mode && (acc_n % 2 == 1)) stall_left = 2;
        end else begin
            bus.ack <= 1'b0;
        end
        if (stall_left > 0) begin
            bus.stall <= 1'b1;
            stall_left--;
        end else begin
            bus.stall <= 1'b0;
        end
    end

    // Monitor: pops expected requests and completions.
    logic        prev_cyc = 0;
    logic        prev_we = 0;
    logic        hold_v = 0;
    logic [31:0] hold_adr = 0;
    always @(negedge clk) begin
        req_t e;
        if (!rst_n) begin
            hold_v   = 0;
            prev_cyc = 0;
        end else begin
            if (bus.stb) begin
                total++;
                if (!bus.cyc) begin
                    bad++;
                    $display("FAIL stb_no_cyc cyc=%b required=1", bus.cyc);
                end
            end
            if (hold_v && bus.stb) begin
                total++;
                if (bus.adr !== hold_adr) begin
                    bad++;
                    $display("FAIL stall_hold adr=%h required=%h",
                             bus.adr, hold_adr);
                end
            end
            hold_v   = bus.cyc && bus.stb && bus.stall;
            hold_adr = bus.adr;
            if (bus.cyc && bus.stb && !bus.stall) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_req we=%b adr=%h", bus.we, bus.adr);
                end else begin
                    e = exp_q.pop_front();
                    if (bus.we !== e.we || bus.adr !== e.adr ||
                        bus.sel !== 4'hF ||
                        (e.we && bus.dat_m !== e.dat)) begin
                        bad++;
                        $display("FAIL req we=%b adr=%h sel=%h dat=%h required we=%b adr=%h sel=f dat=%h",
                                 bus.we, bus.adr, bus.sel, bus.dat_m,
                                 e.we, e.adr, e.dat);
                    end
                end
            end
            if (bus.cyc && prev_cyc && bus.we != prev_we) begin
                total++;
                bad++;
                $display("FAIL phase_gap we=%b prev_we=%b cyc stayed high",
                         bus.we, prev_we);
            end
            prev_cyc = bus.cyc;
            prev_we  = bus.we;
            if (done) begin
                done_cnt++;
                total++;
                if (done_q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_done test=%0d", cur_test);
                end else if (done_q.pop_front() != cur_test) begin
                    bad++;
                    $display("FAIL done_id test=%0d", cur_test);
                end
            end
            if (err) begin
                err_cnt++;
                if (!err_allowed) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_err err=1 required=0");
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic preload(input logic [31:0] base, input int n,
                           input logic [31:0] seed);
        for (int i = 0; i < n; i++) begin
            gold[base + 32'(4 * i)] = seed + 32'(i);
            mem[base + 32'(4 * i)]  = seed + 32'(i);
        end
    endtask

    task automatic push_copy(input logic [31:0] s, input logic [31:0] d,
                             input int l, input int id);
        req_t r;
        int   n;
        while (l > 0) begin
            n = (l > 4) ? 4 : l;
            for (int i = 0; i < n; i++) begin
                r.we = 0; r.adr = s + 32'(4 * i); r.dat = 0;
                exp_q.push_back(r);
            end
            for (int i = 0; i < n; i++) begin
                r.we = 1; r.adr = d + 32'(4 * i); r.dat = gold[s + 32'(4 * i)];
                exp_q.push_back(r);
            end
            s = s + 32'(4 * n);
            d = d + 32'(4 * n);
            l = l - n;
        end
        done_q.push_back(id);
    endtask

    task automatic start_cmd(input logic [31:0] s, input logic [31:0] d,
                             input logic [15:0] l);
        @(negedge clk);
        src = s; dst = d; len = l; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int d0, input int budget, input string name);
        int c = 0;
        while (done_cnt == d0 && c < budget) begin
            @(posedge clk);
            c++;
        end
        @(negedge clk);
        chk(name, 32'(done_cnt - d0), 32'd1);
    endtask

    task automatic copy_test(input int id, input logic [31:0] s,
                             input logic [31:0] d, input int l,
                             input logic [31:0] seed, input string name);
        int d0;
        cur_test = id;
        preload(s, l, seed);
        push_copy(s, d, l, id);
        d0 = done_cnt;
        start_cmd(s, d, 16'(l));
        wait_done(d0, 60 * l + 20, name);
        for (int i = 0; i < l; i++)
            chk(name, rd(d + 32'(4 * i)), seed + 32'(i));
        chk("queue_empty", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    initial begin
        int d0;
        int c;
        repeat (3) @(negedge clk);
        chk("rst_cyc", 32'(bus.cyc), 32'd0);
        chk("rst_stb", 32'(bus.stb), 32'd0);
        chk("rst_adr", bus.adr, 32'h0);
        chk("rst_sel", 32'(bus.sel), 32'd0);
        chk("rst_dat", bus.dat_m, 32'h0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // zero length: done two edges after start, no bus activity
        cur_test = 1;
        done_q.push_back(1);
        start_cmd(32'h10, 32'h20, 16'd0);
        chk("len0_busy", 32'(busy), 32'd1);
        chk("len0_done_early", 32'(done), 32'd0);
        @(negedge clk);
        chk("len0_done", 32'(done), 32'd1);
        chk("len0_busy_end", 32'(busy), 32'd0);
        @(negedge clk);

        // single word with start-to-cyc latency
        cur_test = 2;
        gold[32'h100] = 32'hDEADBEEF;
        mem[32'h100]  = 32'hDEADBEEF;
        push_copy(32'h100, 32'h200, 1, 2);
        d0 = done_cnt;
        start_cmd(32'h101, 32'h203, 16'd1);
        chk("lat_cyc", 32'(bus.cyc), 32'd1);
        chk("lat_adr", bus.adr, 32'h100);
        wait_done(d0, 30, "len1_done");
        chk("len1_data", rd(32'h200), 32'hDEADBEEF);

        // ten words, bursts 4/4/2, with an ignored start mid-transfer
        cur_test = 3;
        preload(32'h1000, 10, 32'hC0DE0000);
        push_copy(32'h1000, 32'h2000, 10, 3);
        d0 = done_cnt;
        start_cmd(32'h1000, 32'h2000, 16'd10);
        repeat (4) @(negedge clk);
        start_cmd(32'h9000, 32'h9100, 16'd3);
        chk("mid_start_busy", 32'(busy), 32'd1);
        wait_done(d0, 200, "len10_done");
        for (int i = 0; i < 10; i++)
            chk("len10_data", rd(32'h2000 + 32'(4 * i)), 32'hC0DE0000 + 32'(i));
        chk("queue_empty", 32'(exp_q.size()), 32'd0);

        // stalls on every second request
        acc_n = 0;
        stall_mode = 1;
        copy_test(4, 32'h5000, 32'h6000, 6, 32'h5A5A0000, "stall6");
        stall_mode = 0;
        repeat (3) @(negedge clk);

        // reset mid-burst, then a fresh transfer
        cur_test = 5;
        preload(32'h7000, 8, 32'h77000000);
        push_copy(32'h7000, 32'h7800, 8, 5);
        start_cmd(32'h7000, 32'h7800, 16'd8);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_cyc", 32'(bus.cyc), 32'd0);
        chk("mid_rst_stb", 32'(bus.stb), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        exp_q.delete();
        done_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        copy_test(6, 32'h3000, 32'h4000, 2, 32'h12340000, "after_rst");

`ifdef WB_DMA_TIMEOUT_EN
        // slave never acks: abort with err, no done, then recover
        begin
            req_t r;
            cur_test = 7;
            noack = 1;
            err_allowed = 1;
            r.we = 0; r.adr = 32'hA000; r.dat = 0;
            exp_q.push_back(r);
            d0 = done_cnt;
            c = err_cnt;
            start_cmd(32'hA000, 32'hA100, 16'd1);
            for (int i = 0; i < 40 && err_cnt == c; i++) @(negedge clk);
            chk("to_err", 32'(err_cnt - c), 32'd1);
            chk("to_cyc", 32'(bus.cyc), 32'd0);
            chk("to_busy", 32'(busy), 32'd0);
            repeat (3) @(negedge clk);
            chk("to_no_done", 32'(done_cnt - d0), 32'd0);
            chk("to_err_once", 32'(err_cnt - c), 32'd1);
            noack = 0;
            err_allowed = 0;
            copy_test(8, 32'hB000, 32'hB100, 1, 32'hBEEF0000, "after_to");
        end
`else
        c = 0;
        repeat (4) @(negedge clk) c += int'(err);
        chk("err_tied", 32'(c), 32'd0);
`endif

        chk("final_queue", 32'(exp_q.size()), 32'd0);
        chk("final_done_q", 32'(done_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
